// File: rtl/pc_pkg.sv
// Shared types and defaults for the fetch-stage program counter.
// Imported by the PC register and the pc_test top.
package pc_pkg;

  localparam int unsigned PC_WIDTH = 32;
  localparam int unsigned PC_STEP = 4;
  localparam logic [PC_WIDTH-1:0] PC_RESET_ADDR = 32'h0000_0000;

  typedef logic [PC_WIDTH-1:0] pc_t;

endpackage

// File: rtl/pc_reg.sv
// WIDTH-bit state register holding the current PC.
// Asynchronous active-high reset to a parameterised address.
module pc_reg
  import pc_pkg::*;
#(
  parameter int unsigned WIDTH = PC_WIDTH,
  parameter logic [WIDTH-1:0] RESET_ADDR = WIDTH'(PC_RESET_ADDR)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Reset wins immediately; otherwise capture d on every rising edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= RESET_ADDR;
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/pc_test.sv
// Free-running PC fetch stage: PCout advances by STEP each edge.
// PCin is the combinational sequential next address (mod 2^WIDTH).
module pc_test
  import pc_pkg::*;
#(
  parameter int unsigned WIDTH = PC_WIDTH,
  parameter int unsigned STEP = PC_STEP,
  parameter logic [WIDTH-1:0] RESET_ADDR = WIDTH'(PC_RESET_ADDR)
) (
  input  logic             CLK,
  input  logic             Reset,
  output logic [WIDTH-1:0] PCin,
  output logic [WIDTH-1:0] PCout
);

  localparam logic [WIDTH-1:0] INC = WIDTH'(STEP);

  logic [WIDTH-1:0] pc_cur;
  logic [WIDTH-1:0] pc_nxt;

  // Sequential next address; carry out of the top bit is dropped.
  always_comb begin
    pc_nxt = pc_cur + INC;
  end

  pc_reg #(
    .WIDTH      (WIDTH),
    .RESET_ADDR (RESET_ADDR)
  ) u_pc_reg (
    .clk (CLK),
    .rst (Reset),
    .d   (pc_nxt),
    .q   (pc_cur)
  );

  assign PCin  = pc_nxt;
  assign PCout = pc_cur;

endmodule

// File: tb/tb_pc_test.sv
// Directed bench for pc_test: reset, stepping, async reset,
// wrap-around, STEP override and a long count.
module tb_pc_test;

  logic clk;
  logic rst0, rst1, rst2;
  logic [31:0] pcin0, pcout0;
  logic [31:0] pcin1, pcout1;
  logic [31:0] pcin2, pcout2;

  int checks = 0;
  int errors = 0;
  int xseen = 0;

  pc_test u_dut0 (
    .CLK   (clk),
    .Reset (rst0),
    .PCin  (pcin0),
    .PCout (pcout0)
  );

  pc_test #(
    .RESET_ADDR (32'hFFFF_FFF8)
  ) u_dut1 (
    .CLK   (clk),
    .Reset (rst1),
    .PCin  (pcin1),
    .PCout (pcout1)
  );

  pc_test #(
    .STEP       (8),
    .RESET_ADDR (32'h0000_0100)
  ) u_dut2 (
    .CLK   (clk),
    .Reset (rst2),
    .PCin  (pcin2),
    .PCout (pcout2)
  );

  // 200 ns period: rising edges at 100, 300, 500, ...
  initial clk = 1'b0;
  always #100 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst0 = 1'b1;
    rst1 = 1'b1;
    rst2 = 1'b1;

    // Reset held across three rising edges.
    for (int i = 0; i < 3; i++) begin
      edge1();
      chk("rst_pcout", pcout0, 32'h0);
      chk("rst_pcin", pcin0, 32'h4);
    end
    chk("wrap_rst_pcout", pcout1, 32'hFFFF_FFF8);
    chk("wrap_rst_pcin", pcin1, 32'hFFFF_FFFC);
    chk("s8_rst_pcout", pcout2, 32'h100);
    chk("s8_rst_pcin", pcin2, 32'h108);

    // Release mid-low-phase, away from any edge.
    @(negedge clk);
    #50;
    rst0 = 1'b0;
    rst1 = 1'b0;
    rst2 = 1'b0;

    edge1();
    chk("step1_pcout", pcout0, 32'd4);
    chk("step1_pcin", pcin0, 32'd8);
    chk("wrap_e1_pcout", pcout1, 32'hFFFF_FFFC);
    chk("wrap_e1_pcin", pcin1, 32'h0);
    chk("s8_e1_pcout", pcout2, 32'h108);

    edge1();
    chk("step2_pcout", pcout0, 32'd8);
    chk("step2_pcin", pcin0, 32'd12);
    chk("wrap_e2_pcout", pcout1, 32'h0);
    chk("wrap_e2_pcin", pcin1, 32'h4);
    chk("s8_e2_pcout", pcout2, 32'h110);

    edge1();
    chk("step3_pcout", pcout0, 32'd12);
    chk("step3_pcin", pcin0, 32'd16);
    chk("s8_e3_pcout", pcout2, 32'h118);
    chk("s8_e3_pcin", pcin2, 32'h120);

    edge1();
    chk("step4_pcout", pcout0, 32'd16);
    chk("step4_pcin", pcin0, 32'd20);

    edge1();
    chk("step5_pcout", pcout0, 32'd20);
    chk("step5_pcin", pcin0, 32'd24);

    // Five more edges: ten in total since release.
    for (int i = 0; i < 5; i++) edge1();
    chk("step10_pcout", pcout0, 32'd40);
    chk("step10_pcin", pcin0, 32'd44);

    // Async reset mid-high-phase: no clock edge involved.
    #49;
    rst0 = 1'b1;
    #1;
    chk("async_pcout", pcout0, 32'h0);
    chk("async_pcin", pcin0, 32'h4);

    edge1();
    chk("async_hold_pcout", pcout0, 32'h0);

    @(negedge clk);
    #50;
    rst0 = 1'b0;
    edge1();
    chk("resume_pcout", pcout0, 32'd4);
    chk("resume_pcin", pcin0, 32'd8);

    // Long run of 1000 edges from reset.
    @(negedge clk);
    rst0 = 1'b1;
    #50;
    rst0 = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      edge1();
      if ($isunknown(pcout0) || $isunknown(pcin0)) xseen++;
    end
    chk("long_no_x", 32'(xseen), 32'd0);
    chk("long_pcout", pcout0, 32'd4000);
    chk("long_pcin", pcin0, 32'd4004);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
